// File: rtl/i2s_led_pkg.sv
// Shared types and header layout for the I2S LED tile demux.
package i2s_led_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    LATCH   = 2'd3
  } state_t;

  localparam int unsigned HDR_W     = 16;
  localparam int unsigned NX_MSB    = 15;
  localparam int unsigned NY_MSB    = 11;
  localparam int unsigned BLANK_BIT = 7;
  localparam int unsigned RSVD_BIT  = 6;
  localparam int unsigned ROW_MSB   = 5;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/i2s_grid_counter.sv
// Column/line counter pair over an nx*TILE_W by ny*TILE_H bit grid.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_clr             restart both counters at zero
//   i_en              advance one bit position
//   i_nx, i_ny        grid size in tiles (1..16)
//   o_col, o_line     current position
//   o_col_last_c      col is at the end of a line
//   o_line_last_c     line is the final line
module i2s_grid_counter
  import i2s_led_pkg::*;
#(
  parameter int unsigned TILE_W = 4,
  parameter int unsigned TILE_H = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clr,
  input  logic                          i_en,
  input  logic [4:0]                    i_nx,
  input  logic [4:0]                    i_ny,
  output logic [$clog2(16*TILE_W)-1:0]  o_col,
  output logic [$clog2(16*TILE_H)-1:0]  o_line,
  output logic                          o_col_last_c,
  output logic                          o_line_last_c
);

  localparam int unsigned COL_W  = $clog2(16*TILE_W);
  localparam int unsigned LINE_W = $clog2(16*TILE_H);

  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic [COL_W:0]    w_col_max;
  logic [LINE_W:0]   w_line_max;

  // One extra bit keeps nx*TILE_W-1 exact for the 16-tile case.
  assign w_col_max     = (COL_W+1)'(32'(i_nx) * TILE_W - 32'd1);
  assign w_line_max    = (LINE_W+1)'(32'(i_ny) * TILE_H - 32'd1);
  assign o_col_last_c  = ({1'b0, r_col} == w_col_max);
  assign o_line_last_c = ({1'b0, r_line} == w_line_max);
  assign o_col         = r_col;
  assign o_line        = r_line;

  // Column wraps into a line increment; line wraps at the grid end.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_en) begin
      if (o_col_last_c) begin
        r_col  <= '0;
        r_line <= o_line_last_c ? '0 : r_line + LINE_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_tile_demux.sv
// Extracts this module's TILE_W x TILE_H window from a synced I2S frame
// and drives the LED shift-register strobes.
// Ports:
//   i2s_clk, rst_n    clock, synchronous active-low reset
//   i2s_data          serial stream, MSB first
//   addr_x, addr_y    module position, sampled when the header completes
//   row_num           panel row for the mux
//   led_data          i2s_data delayed one clock
//   led_shift_en      shift enable aligned with led_data
//   led_lat           latch strobe, LAT_CYCLES clocks long
//   led_oe            output enable, active low
//   frame_done        one-clock pulse after the latch
//   addr_oob          address outside the header's grid
//   frame_cnt         completed frames, wrapping
module i2s_tile_demux
  import i2s_led_pkg::*;
#(
  parameter int unsigned TILE_W     = 4,
  parameter int unsigned TILE_H     = 4,
  parameter logic [7:0]  SYNC       = SYNC_DEFAULT,
  parameter int unsigned LAT_CYCLES = 2
) (
  input  logic       i2s_clk,
  input  logic       rst_n,
  input  logic       i2s_data,
  input  logic [3:0] addr_x,
  input  logic [3:0] addr_y,
  output logic [5:0] row_num,
  output logic       led_data,
  output logic       led_shift_en,
  output logic       led_lat,
  output logic       led_oe,
  output logic       frame_done,
  output logic       addr_oob,
  output logic [7:0] frame_cnt
);

  localparam int unsigned COL_W  = $clog2(16*TILE_W);
  localparam int unsigned LINE_W = $clog2(16*TILE_H);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_sr8;
  logic [HDR_W-2:0]  r_hdr;     // the 16th header bit is taken straight from i2s_data
  logic [3:0]        r_hcnt;
  logic [3:0]        r_lcnt;
  logic [4:0]        r_nx, r_ny;
  logic              r_blank;
  logic [5:0]        r_row;
  logic [COL_W-1:0]  r_col_lo;
  logic [LINE_W-1:0] r_line_lo;

  logic [5:0] r_row_num;
  logic       r_led_data, r_led_shift_en, r_led_lat, r_led_oe;
  logic       r_frame_done, r_addr_oob;
  logic [7:0] r_frame_cnt;

  logic [HDR_W-1:0]  w_hdr_full;
  logic              w_unused_rsvd;
  logic              w_sync_hit, w_hdr_last, w_lat_last, w_hdr_done, w_cnt_en;
  logic [COL_W-1:0]  w_col;
  logic [LINE_W-1:0] w_line;
  logic              w_col_last, w_line_last, w_win_c;

  assign w_hdr_full    = {r_hdr, i2s_data};
  assign w_unused_rsvd = w_hdr_full[RSVD_BIT];
  assign w_sync_hit    = ({r_sr8[6:0], i2s_data} == SYNC);
  assign w_hdr_last    = (r_hcnt == 4'(HDR_W-1));
  assign w_lat_last    = (r_lcnt == 4'(LAT_CYCLES-1));

  i2s_grid_counter #(.TILE_W(TILE_W), .TILE_H(TILE_H)) u_grid (
    .clk          (i2s_clk),
    .rst_n        (rst_n),
    .i_clr        (w_hdr_done),
    .i_en         (w_cnt_en),
    .i_nx         (r_nx),
    .i_ny         (r_ny),
    .o_col        (w_col),
    .o_line       (w_line),
    .o_col_last_c (w_col_last),
    .o_line_last_c(w_line_last)
  );

  // Tile window test, widened by one bit so col_lo+TILE_W cannot overflow.
  assign w_win_c = ({1'b0, w_col}  >= {1'b0, r_col_lo}) &&
                   ({1'b0, w_col}  <  ({1'b0, r_col_lo} + (COL_W+1)'(TILE_W))) &&
                   ({1'b0, w_line} >= {1'b0, r_line_lo}) &&
                   ({1'b0, w_line} <  ({1'b0, r_line_lo} + (LINE_W+1)'(TILE_H))) &&
                   !r_addr_oob;

  // State register.
  always_ff @(posedge i2s_clk) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_done  = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      HUNT:    if (w_sync_hit) w_state_nxt = HDR;
      HDR:     if (w_hdr_last) begin
                 w_state_nxt = PAYLOAD;
                 w_hdr_done  = 1'b1;
               end
      PAYLOAD: begin
                 w_cnt_en = 1'b1;
                 if (w_col_last && w_line_last) w_state_nxt = LATCH;
               end
      LATCH:   if (w_lat_last) w_state_nxt = HUNT;
      default: w_state_nxt = HUNT;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i2s_clk) begin
    if (!rst_n) begin
      r_sr8          <= '0;
      r_hdr          <= '0;
      r_hcnt         <= '0;
      r_lcnt         <= '0;
      r_nx           <= '0;
      r_ny           <= '0;
      r_blank        <= 1'b0;
      r_row          <= '0;
      r_col_lo       <= '0;
      r_line_lo      <= '0;
      r_row_num      <= '0;
      r_led_data     <= 1'b0;
      r_led_shift_en <= 1'b0;
      r_led_lat      <= 1'b0;
      r_led_oe       <= 1'b1;
      r_frame_done   <= 1'b0;
      r_addr_oob     <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_led_data     <= i2s_data;
      r_led_shift_en <= (r_state == PAYLOAD) && w_win_c;
      r_led_lat      <= (w_state_nxt == LATCH);
      r_frame_done   <= (r_state == LATCH) && w_lat_last;
      case (r_state)
        HUNT: begin
          // Clearing on a hit stops a stale sync tail from aliasing the next hunt.
          r_sr8 <= w_sync_hit ? 8'h00 : {r_sr8[6:0], i2s_data};
          if (w_sync_hit) begin
            r_hcnt   <= '0;
            r_led_oe <= 1'b1;
          end
        end
        HDR: begin
          r_hdr  <= w_hdr_full[HDR_W-2:0];
          r_hcnt <= r_hcnt + 4'd1;
          if (w_hdr_last) begin
            r_nx       <= 5'(w_hdr_full[NX_MSB -: 4]) + 5'd1;
            r_ny       <= 5'(w_hdr_full[NY_MSB -: 4]) + 5'd1;
            r_blank    <= w_hdr_full[BLANK_BIT];
            r_row      <= w_hdr_full[ROW_MSB:0];
            r_col_lo   <= COL_W'(32'(addr_x) * TILE_W);
            r_line_lo  <= LINE_W'(32'(addr_y) * TILE_H);
            r_addr_oob <= ({1'b0, addr_x} >= (5'(w_hdr_full[NX_MSB -: 4]) + 5'd1)) ||
                          ({1'b0, addr_y} >= (5'(w_hdr_full[NY_MSB -: 4]) + 5'd1));
          end
        end
        PAYLOAD: r_lcnt <= '0;
        LATCH: begin
          r_lcnt <= r_lcnt + 4'd1;
          if (r_lcnt == 4'd0) r_row_num <= r_row;
          if (w_lat_last) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_led_oe    <= r_blank;
          end
        end
        default: ;
      endcase
    end
  end

  assign row_num      = r_row_num;
  assign led_data     = r_led_data;
  assign led_shift_en = r_led_shift_en;
  assign led_lat      = r_led_lat;
  assign led_oe       = r_led_oe;
  assign frame_done   = r_frame_done;
  assign addr_oob     = r_addr_oob;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_i2s_tile_demux.sv
// Frame-level bench for i2s_tile_demux: table of frames plus reset and wrap sequences.
module tb_i2s_tile_demux;

  localparam int TW  = 4;
  localparam int TH  = 4;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic [3:0] ax = 4'd0;
  logic [3:0] ay = 4'd0;
  logic [5:0] row_num;
  logic       led_data, led_shift_en, led_lat, led_oe, frame_done, addr_oob;
  logic [7:0] frame_cnt;

  i2s_tile_demux #(.TILE_W(TW), .TILE_H(TH), .SYNC(8'hA5), .LAT_CYCLES(LAT)) dut (
    .i2s_clk     (clk),
    .rst_n       (rst_n),
    .i2s_data    (din),
    .addr_x      (ax),
    .addr_y      (ay),
    .row_num     (row_num),
    .led_data    (led_data),
    .led_shift_en(led_shift_en),
    .led_lat     (led_lat),
    .led_oe      (led_oe),
    .frame_done  (frame_done),
    .addr_oob    (addr_oob),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic en;
  } exp_t;

  typedef struct {
    string      name;
    logic [15:0] hdr;
    logic [3:0] ax;
    logic [3:0] ay;
    int         pre;
    logic [7:0] pat;
    logic       oob;
    logic [5:0] row;
    logic       oe;
  } frame_vec_t;

  exp_t       q[$];
  exp_t       mon_e;
  string      cur = "init";
  int         n_pass = 0;
  int         n_chk = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_oe = 1'b1;
  frame_vec_t vecs[7];
  frame_vec_t fv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got 0x%0h expected 0x%0h", cur, name, act, exp);
  endtask

  // Scoreboard: every driven bit expects led_data/led_shift_en one edge later.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("led_data", 32'(led_data), 32'(mon_e.d));
      check("led_shift_en", 32'(led_shift_en), 32'(mon_e.en));
    end
  end

  task automatic drive(input logic b, input logic en_exp);
    exp_t e;
    @(negedge clk);
    din  = b;
    e.d  = b;
    e.en = en_exp;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs();
    check("rst row_num", 32'(row_num), 32'd0);
    check("rst led_data", 32'(led_data), 32'd0);
    check("rst led_shift_en", 32'(led_shift_en), 32'd0);
    check("rst led_lat", 32'(led_lat), 32'd0);
    check("rst led_oe", 32'(led_oe), 32'd1);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst addr_oob", 32'(addr_oob), 32'd0);
    check("rst frame_cnt", 32'(frame_cnt), 32'd0);
  endtask

  // Random hunt bits that never form the sync byte; the last four are zero so
  // no suffix of them can merge with the following sync into an early match.
  task automatic send_pre(input int n);
    logic [7:0] w;
    logic       b;
    w = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (i >= n - 4) b = 1'b0;
      else begin
        b = 1'($urandom_range(0, 1));
        if ({w[6:0], b} == 8'hA5) b = ~b;
      end
      w = {w[6:0], b};
      drive(b, 1'b0);
      tick();
      check("hunt led_oe", 32'(led_oe), 32'(exp_oe));
    end
  endtask

  task automatic run_frame(input frame_vec_t v, input int abort_at);
    logic [7:0] sync;
    int nx, ny, lw, total, col, line;
    logic b, en;
    cur  = v.name;
    sync = 8'hA5;
    ax   = v.ax;
    ay   = v.ay;
    nx   = int'(v.hdr[15:12]) + 1;
    ny   = int'(v.hdr[11:8]) + 1;
    lw   = nx * TW;
    total = lw * ny * TH;
    send_pre(v.pre);
    for (int i = 7; i >= 0; i--) drive(sync[i], 1'b0);
    for (int i = 15; i >= 0; i--) drive(v.hdr[i], 1'b0);
    tick();
    check("addr_oob", 32'(addr_oob), 32'(v.oob));
    for (int k = 0; k < total; k++) begin
      if (k == abort_at) begin
        @(negedge clk);
        din   = 1'b0;
        rst_n = 1'b0;
        tick();
        check_reset_outputs();
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        exp_oe  = 1'b1;
        for (int i = 0; i < 80; i++) begin
          drive(1'b0, 1'b0);
          tick();
          check("post-reset led_lat", 32'(led_lat), 32'd0);
        end
        return;
      end
      b    = v.pat[7 - (k % 8)];
      col  = k % lw;
      line = k / lw;
      en   = !v.oob && (col / TW == int'(v.ax)) && (line / TH == int'(v.ay));
      drive(b, en);
      if (k == 0) begin
        tick();
        check("payload led_oe", 32'(led_oe), 32'd1);
      end
    end
    tick();
    check("latch start led_lat", 32'(led_lat), 32'd1);
    for (int i = 0; i < LAT; i++) begin
      drive(1'b0, 1'b0);
      tick();
      if (i < LAT - 1) begin
        check("latch led_lat", 32'(led_lat), 32'd1);
        check("latch frame_done", 32'(frame_done), 32'd0);
      end else begin
        exp_cnt = exp_cnt + 8'd1;
        check("end led_lat", 32'(led_lat), 32'd0);
        check("frame_done", 32'(frame_done), 32'd1);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("led_oe", 32'(led_oe), 32'(v.oe));
        check("row_num", 32'(row_num), 32'(v.row));
      end
    end
    exp_oe = v.oe;
    drive(1'b0, 1'b0);
    tick();
    check("frame_done pulse", 32'(frame_done), 32'd0);
    check("idle led_lat", 32'(led_lat), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"basic",      16'h1105, 4'd1,  4'd0, 0,  8'h3C, 1'b0, 6'd5,  1'b0};
    vecs[1] = '{"blank",      16'h1185, 4'd1,  4'd0, 0,  8'hA5, 1'b0, 6'd5,  1'b1};
    vecs[2] = '{"oob_1x1",    16'h0003, 4'd2,  4'd0, 0,  8'hFF, 1'b1, 6'd3,  1'b0};
    vecs[3] = '{"sync_hunt",  16'h1105, 4'd0,  4'd1, 37, 8'hA5, 1'b0, 6'd5,  1'b0};
    vecs[4] = '{"grid3x11",   16'h2A07, 4'd2,  4'd10, 5, 8'h69, 1'b0, 6'd7,  1'b0};
    vecs[5] = '{"rsvd_bit",   16'h1142, 4'd1,  4'd1, 0,  8'hC3, 1'b0, 6'd2,  1'b0};
    vecs[6] = '{"oob_y",      16'h1100, 4'd0,  4'd2, 0,  8'h5A, 1'b1, 6'd0,  1'b0};

    cur   = "reset";
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tick();
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], -1);

    fv = '{"max_grid", 16'hFF3F, 4'd15, 4'd15, 0, 8'h96, 1'b0, 6'd63, 1'b0};
    run_frame(fv, -1);

    fv = vecs[0];
    fv.name = "reset_mid";
    run_frame(fv, 20);
    fv.name = "after_reset";
    run_frame(fv, -1);

    fv = '{"wrap", 16'h0000, 4'd0, 4'd0, 0, 8'h5A, 1'b0, 6'd0, 1'b0};
    while (exp_cnt != 8'd0) run_frame(fv, -1);
    cur = "wrap_final";
    check("frame_cnt wrapped", 32'(frame_cnt), 32'd0);

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2s_tile_demux.md
Name: i2s_tile_demux

Overview:
- Parametrised successor to the per-module I2S stream mask. Sits between the I2S receiver pins and one LED panel module's shift-register drivers.
- Hunts for a sync byte on the serial stream, then parses a 16-bit header giving grid size, flags and row number.
- From the payload it gates out only the TILE_W x TILE_H bit window belonging to this module's (addr_x, addr_y) position, then latches the data and enables the outputs.
- Uses line/column counters instead of a flat bit count; it also adds sync hunting, a blank flag, out-of-range detection and a frame counter.

Parameters:
- TILE_W, 4, bits per module per line (1..16)
- TILE_H, 4, lines per module (1..16)
- SYNC, 8'hA5, frame sync byte, received MSB first
- LAT_CYCLES, 2, led_lat high duration in clocks (1..15)

Ports:
- i2s_clk  in  1  single clock; i2s_data is sampled on the rising edge
- rst_n  in  1  synchronous active-low reset
- i2s_data  in  1  serial stream, MSB first
- addr_x  in  4  module column index; sampled when the header completes
- addr_y  in  4  module row index; sampled when the header completes
- row_num  out  6  panel row driven to the mux
- led_data  out  1  registered copy of i2s_data
- led_shift_en  out  1  shift-clock enable, aligned with led_data; the top-level ICG gates i2s_clk with it
- led_lat  out  1  driver latch strobe
- led_oe  out  1  driver output enable, active low (1 = blanked)
- frame_done  out  1  one-cycle pulse at the end of LATCH
- addr_oob  out  1  high when the sampled address lies outside the header's grid; holds until the next header
- frame_cnt  out  8  count of completed frames, wraps

Behaviour:
- Reset (rst_n low at a clock edge): state HUNT, all counters 0, row_num=0, led_data=0, led_shift_en=0, led_lat=0, led_oe=1, frame_done=0, addr_oob=0, frame_cnt=0. A reset mid-frame aborts the frame with no latch.
- Internally, sr8 is an 8-bit sync shift register; hdr is the 16-bit header register.
- HUNT:
  - Shift i2s_data into sr8 each cycle.
  - When {sr8[6:0], i2s_data} == SYNC, go to HDR; that bit is the last sync bit.
  - Sync matching is bit-aligned; payload bits can alias SYNC only while in HUNT.
- HDR:
  - Shift 16 bits into hdr, MSB first; a 4-bit counter runs 0..15.
  - On the 16th bit, fields are decoded from the final value {hdr[14:0], i2s_data}: nx = [15:12]+1, ny = [11:8]+1, blank = [7], [6] reserved/ignored, row = [5:0].
  - Also on the 16th bit: sample addr_x/addr_y; compute col_lo = addr_x*TILE_W and line_lo = addr_y*TILE_H (constant multiply); set addr_oob = (addr_x >= nx) | (addr_y >= ny); clear the col and line counters.
  - Go to PAYLOAD. The first payload bit is the next cycle.
- PAYLOAD:
  - col counts 0..nx*TILE_W-1. When it wraps, line increments; line counts 0..ny*TILE_H-1.
  - Counter widths: col clog2(16*TILE_W), line clog2(16*TILE_H).
  - Window condition: col in [col_lo, col_lo+TILE_W) AND line in [line_lo, line_lo+TILE_H) AND !addr_oob.
  - led_shift_en is the window condition registered one cycle, matching the led_data latency.
  - At col = max and line = max: go to LATCH.
  - led_oe = 1 throughout HDR and PAYLOAD.
- LATCH:
  - led_lat = 1 for LAT_CYCLES cycles; led_shift_en = 0.
  - row_num <= row on the first LATCH cycle.
  - On the last LATCH cycle: frame_done pulses, frame_cnt increments, led_lat drops next cycle, led_oe <= blank, state goes to HUNT.
- led_oe stays at that value until the next header completes. addr_oob frames still latch, clocking zero bits.
- led_data = i2s_data delayed one cycle, in every state.

Decomposition:
- Package i2s_led_pkg holds:
  - the state enum (HUNT, HDR, PAYLOAD, LATCH);
  - header field bit positions: NX_MSB=15, NY_MSB=11, BLANK_BIT=7, ROW_MSB=5;
  - HDR_W=16 and the default SYNC.
- One sub-module, i2s_grid_counter: the parametrised col/line counter pair with wrap and last flags. It is reusable by the panel-side row scanner.

Test Plan:
- Basic window: TILE 4x4, send A5 then header 0x1105 (nx=2, ny=2, row 5), addr (1,0), 64 payload bits.
  - led_shift_en is high for payload bits 4-7, 12-15, 20-23, 28-31 (16 cycles), each aligned with led_data.
  - led_lat is high for 2 cycles after bit 63; row_num becomes 5; led_oe goes to 0; frame_cnt=1.
- Blank flag: same frame with header 0x1185. After LATCH, led_oe stays 1; row_num=5; frame_done pulses once.
- Out of range: header 0x0003 (1x1 grid), addr (2,0). addr_oob=1, led_shift_en never asserts, latch still occurs after 16 bits.
- Sync hunt: 37 random bits containing no A5, then A5 and a valid frame. No state exit before the sync; the frame decodes correctly. An A5 pattern embedded in payload data must not restart the header.
- Reset mid-PAYLOAD: rst_n low for 1 cycle at payload bit 20. All outputs return to reset values with no led_lat pulse; the next A5 frame is processed normally.
- Max grid: header 0xFF3F, addr (15,15). The window is the last 4 bits of each of the final 4 lines (col 60-63, lines 60-63); total 4096 payload bits; frame_cnt wraps from 255 to 0 on the 256th frame.
